// File: rtl/atom_share_arbiter.sv
// atom_share_arbiter: round-robin arbiter in front of one read-add-write atom.
// One requester per cycle adds its operand (packet or shared constant) to the
// state register. The winner gets old/new state back through a response
// register with backpressure. A control-plane load overwrites the state and
// takes priority over packet traffic.

// Per-requester operand select; its output is only ever consumed by registers.
module atom_share_lane #(
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   sel,
  input  logic [COUNT_WIDTH-1:0] pkt,
  input  logic [COUNT_WIDTH-1:0] constant,
  output logic [COUNT_WIDTH-1:0] operand
);
  assign operand = sel ? pkt : constant;
endmodule

module atom_share_arbiter #(
  parameter  int COUNT_WIDTH = 3,
  parameter  int NUM_REQ     = 4,
  localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             i__req_valid,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] i__req_pkt,
  input  logic [NUM_REQ-1:0]             i__req_sel,
  output logic [NUM_REQ-1:0]             o__req_ready,
  input  logic [COUNT_WIDTH-1:0]         i__constant,
  input  logic                           i__cfg_load,
  input  logic [COUNT_WIDTH-1:0]         i__cfg_value,
  output logic                           o__resp_valid,
  input  logic                           i__resp_ready,
  output logic [ID_WIDTH-1:0]            o__resp_id,
  output logic [COUNT_WIDTH-1:0]         o__resp_old,
  output logic [COUNT_WIDTH-1:0]         o__resp_new,
  output logic [COUNT_WIDTH-1:0]         o__state
);

  typedef struct packed {
    logic                   valid;
    logic [ID_WIDTH-1:0]    id;
    logic [COUNT_WIDTH-1:0] old_val;
    logic [COUNT_WIDTH-1:0] new_val;
  } resp_t;

  logic [COUNT_WIDTH-1:0]              state;
  logic [ID_WIDTH-1:0]                 rr_ptr;
  resp_t                               resp;

  logic [NUM_REQ-1:0][COUNT_WIDTH-1:0] lane_op;
  logic                                can_issue;
  logic                                any_gnt;
  logic [NUM_REQ-1:0]                  gnt;
  logic [ID_WIDTH-1:0]                 gnt_id;
  logic [COUNT_WIDTH-1:0]              sum_val;

  genvar k;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_lane
      atom_share_lane #(.COUNT_WIDTH(COUNT_WIDTH)) u_lane (
        .sel      (i__req_sel[k]),
        .pkt      (i__req_pkt[k*COUNT_WIDTH +: COUNT_WIDTH]),
        .constant (i__constant),
        .operand  (lane_op[k])
      );
    end
  endgenerate

  // Reset also blocks issue so nothing is accepted while rst_n is low.
  assign can_issue = rst_n && !i__cfg_load && (!resp.valid || i__resp_ready);

  // Rotating priority scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    logic [ID_WIDTH:0] idx;
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
      if (idx >= (ID_WIDTH+1)'(NUM_REQ)) idx = idx - (ID_WIDTH+1)'(NUM_REQ);
      if (!any_gnt && can_issue && i__req_valid[idx[ID_WIDTH-1:0]]) begin
        any_gnt = 1'b1;
        gnt_id  = idx[ID_WIDTH-1:0];
      end
    end
    if (any_gnt) gnt[gnt_id] = 1'b1;
  end

  // Carry out of the add is dropped: the atom counts modulo 2^COUNT_WIDTH.
  assign sum_val = state + lane_op[gnt_id];

  // State register and round-robin pointer; a config load outranks any grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= '0;
      rr_ptr <= '0;
    end else if (i__cfg_load) begin
      state  <= i__cfg_value;
    end else if (any_gnt) begin
      state  <= sum_val;
      rr_ptr <= (gnt_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Response register: reload on grant (covers back-to-back), else clear on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp <= '0;
    end else if (any_gnt) begin
      resp.valid   <= 1'b1;
      resp.id      <= gnt_id;
      resp.old_val <= state;
      resp.new_val <= sum_val;
    end else if (resp.valid && i__resp_ready) begin
      resp.valid   <= 1'b0;
    end
  end

  assign o__req_ready  = gnt;
  assign o__resp_valid = resp.valid;
  assign o__resp_id    = resp.id;
  assign o__resp_old   = resp.old_val;
  assign o__resp_new   = resp.new_val;
  assign o__state      = state;

endmodule

// File: tb/tb_atom_share_arbiter.sv
// Directed bench for atom_share_arbiter (W=3, NUM_REQ=4).
// Response tuple compared per cycle as {valid, id, old, new, state}.
module tb_atom_share_arbiter;
  localparam int W = 3;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_pkt;
  logic [N-1:0] req_sel;
  logic [N-1:0] req_ready;
  logic [W-1:0] constant;
  logic         cfg_load;
  logic [W-1:0] cfg_value;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [W-1:0] resp_old;
  logic [W-1:0] resp_new;
  logic [W-1:0] state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  atom_share_arbiter #(.COUNT_WIDTH(W), .NUM_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i__req_valid (req_valid),
    .i__req_pkt   (req_pkt),
    .i__req_sel   (req_sel),
    .o__req_ready (req_ready),
    .i__constant  (constant),
    .i__cfg_load  (cfg_load),
    .i__cfg_value (cfg_value),
    .o__resp_valid(resp_valid),
    .i__resp_ready(resp_ready),
    .o__resp_id   (resp_id),
    .o__resp_old  (resp_old),
    .o__resp_new  (resp_new),
    .o__state     (state)
  );

  wire [11:0] tup = {resp_valid, resp_id, resp_old, resp_new, state};

  // Advance one clock and settle 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_pkt    = 12'($urandom);
    req_sel    = 4'($urandom);
    constant   = 3'($urandom);
    cfg_load   = 1'($urandom);
    cfg_value  = 3'($urandom);
    resp_ready = 1'($urandom);
    #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    tick();
    tick();
    rst_n = 1'b1; req_valid = '0; cfg_load = 1'b0; resp_ready = 1'b1;
    #1;
    n_vec++;
    if (tup !== 12'h000) begin
      n_err++; $display("FAIL reset_outputs: got %h want 000", tup);
    end
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_idle_ready: got %b want 0000", req_ready);
    end
  endtask

  task automatic test_single_wrap();
    req_valid = 4'b0010; req_sel = 4'b0010; req_pkt = '0; req_pkt[1*W +: W] = 3'd5;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL single_ready: got %b want 0010", req_ready);
    end
    tick();
    n_vec++;
    if (tup !== {1'b1, 2'd1, 3'd0, 3'd5, 3'd5}) begin
      n_err++; $display("FAIL single_resp: got %h want %h", tup, {1'b1, 2'd1, 3'd0, 3'd5, 3'd5});
    end
    req_sel = 4'b0000; constant = 3'd4;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL wrap_ready: got %b want 0010", req_ready);
    end
    tick();
    n_vec++;
    if (tup !== {1'b1, 2'd1, 3'd5, 3'd1, 3'd1}) begin
      n_err++; $display("FAIL wrap_resp: got %h want %h", tup, {1'b1, 2'd1, 3'd5, 3'd1, 3'd1});
    end
    req_valid = '0;
    tick();
    n_vec++;
    if (resp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: got %b want 0", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'hF; req_sel = 4'hF; req_pkt = {3'd1, 3'd1, 3'd1, 3'd1}; resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
      end
      tick();
      n_vec++;
      if (tup !== {1'b1, 2'(c % 4), 3'(c), 3'(c + 1), 3'(c + 1)}) begin
        n_err++; $display("FAIL rr_resp[%0d]: got %h want %h", c, tup,
                          {1'b1, 2'(c % 4), 3'(c), 3'(c + 1), 3'(c + 1)});
      end
    end
    req_valid = '0;
    tick();
  endtask

  // State 5, rr_ptr 1 on entry.
  task automatic test_backpressure();
    req_valid = 4'b0010; req_sel = 4'b0110; req_pkt = '0;
    req_pkt[1*W +: W] = 3'd2; req_pkt[2*W +: W] = 3'd1; resp_ready = 1'b1;
    tick();
    n_vec++;
    if (tup !== {1'b1, 2'd1, 3'd5, 3'd7, 3'd7}) begin
      n_err++; $display("FAIL bp_first: got %h want %h", tup, {1'b1, 2'd1, 3'd5, 3'd7, 3'd7});
    end
    req_valid = 4'b0100; resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready);
      end
      tick();
      n_vec++;
      if (tup !== {1'b1, 2'd1, 3'd5, 3'd7, 3'd7}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", c, tup, {1'b1, 2'd1, 3'd5, 3'd7, 3'd7});
      end
    end
    resp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_release_ready: got %b want 0100", req_ready);
    end
    tick();
    n_vec++;
    if (tup !== {1'b1, 2'd2, 3'd7, 3'd0, 3'd0}) begin
      n_err++; $display("FAIL bp_release_resp: got %h want %h", tup, {1'b1, 2'd2, 3'd7, 3'd0, 3'd0});
    end
    req_valid = '0;
    tick();
  endtask

  // State 0, rr_ptr 3 on entry; a grant to req3 moves rr_ptr to 0 first.
  task automatic test_cfg_priority();
    req_valid = 4'b1000; req_sel = 4'b1001; req_pkt = '0;
    req_pkt[3*W +: W] = 3'd1; req_pkt[0*W +: W] = 3'd3;
    tick();
    n_vec++;
    if (tup !== {1'b1, 2'd3, 3'd0, 3'd1, 3'd1}) begin
      n_err++; $display("FAIL cfg_pre: got %h want %h", tup, {1'b1, 2'd3, 3'd0, 3'd1, 3'd1});
    end
    cfg_load = 1'b1; cfg_value = 3'd6; req_valid = 4'b1001;
    #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL cfg_ready: got %b want 0000", req_ready);
    end
    tick();
    n_vec++;
    if ({resp_valid, state} !== {1'b0, 3'd6}) begin
      n_err++; $display("FAIL cfg_state: got %h want %h", {resp_valid, state}, {1'b0, 3'd6});
    end
    cfg_load = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL cfg_next_ready: got %b want 0001", req_ready);
    end
    tick();
    n_vec++;
    if (tup !== {1'b1, 2'd0, 3'd6, 3'd1, 3'd1}) begin
      n_err++; $display("FAIL cfg_next_resp: got %h want %h", tup, {1'b1, 2'd0, 3'd6, 3'd1, 3'd1});
    end
    req_valid = '0;
    tick();
  endtask

  // State 1, rr_ptr 1 on entry.
  task automatic test_reset_mid();
    req_valid = 4'b0100; req_sel = 4'b0101; req_pkt = '0;
    req_pkt[2*W +: W] = 3'd1; req_pkt[0*W +: W] = 3'd3; resp_ready = 1'b1;
    tick();
    n_vec++;
    if (tup !== {1'b1, 2'd2, 3'd1, 3'd2, 3'd2}) begin
      n_err++; $display("FAIL mid_pending: got %h want %h", tup, {1'b1, 2'd2, 3'd1, 3'd2, 3'd2});
    end
    resp_ready = 1'b0; rst_n = 1'b0; req_valid = 4'b0101;
    #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready);
    end
    tick();
    n_vec++;
    if (tup !== 12'h000) begin
      n_err++; $display("FAIL mid_rst_outputs: got %h want 000", tup);
    end
    rst_n = 1'b1; resp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL mid_first_ready: got %b want 0001", req_ready);
    end
    tick();
    n_vec++;
    if (tup !== {1'b1, 2'd0, 3'd0, 3'd3, 3'd3}) begin
      n_err++; $display("FAIL mid_first_resp: got %h want %h", tup, {1'b1, 2'd0, 3'd0, 3'd3, 3'd3});
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_wrap();
    test_round_robin();
    test_backpressure();
    test_cfg_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
